// File: rtl/branch_prediction_queue.sv
// In-order queue of BTB predictions from IF to EX; checks each prediction at
// resolve time and emits a registered redirect and BTB update.
module branch_prediction_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enq_valid,
    output logic                       o_enq_ready,
    input  logic [XLEN-1:0]            i_enq_pc,
    input  logic                       i_enq_pred_taken,
    input  logic [XLEN-1:0]            i_enq_pred_target,
    input  logic                       i_res_valid,
    input  logic                       i_res_is_branch,
    input  logic                       i_res_taken,
    input  logic [XLEN-1:0]            i_res_target,
    input  logic [XLEN-1:0]            i_res_next_pc,
    input  logic                       i_flush,
    output logic                       o_redirect,
    output logic [XLEN-1:0]            o_redirect_pc,
    output logic                       o_btb_update,
    output logic [XLEN-1:0]            o_btb_update_pc,
    output logic [XLEN-1:0]            o_btb_update_target,
    output logic                       o_btb_update_taken,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            upd_q, upd_d;
    logic [XLEN-1:0] upd_pc_q, upd_pc_d, upd_tgt_q, upd_tgt_d;
    logic            upd_taken_q, upd_taken_d;
    logic            underflow_q, underflow_d;

    entry_t head;
    logic   empty, full, pop, push, mispredict, flush_now, act_taken;

    always_comb begin
        empty      = (cnt_q == '0);
        full       = (cnt_q == CW'(DEPTH));
        head       = mem_q[rd_q];
        // i_flush overrides a simultaneous resolve entirely
        pop        = i_res_valid && !i_flush && !empty;
        act_taken  = i_res_is_branch && i_res_taken;
        mispredict = 1'b0;
        if (pop) begin
            if (i_res_is_branch)
                mispredict = (head.pred_taken != i_res_taken) ||
                             (i_res_taken && (head.pred_target != i_res_target));
            else
                mispredict = head.pred_taken;
        end
        flush_now  = i_flush || mispredict;
        push       = i_enq_valid && !full && !flush_now;

        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_now) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = '{pc: i_enq_pc, pred_taken: i_enq_pred_taken,
                                pred_target: i_enq_pred_target};
                wr_d = wr_q + AW'(1);
            end
            if (pop)
                rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end

        redirect_d    = mispredict;
        redirect_pc_d = '0;
        if (mispredict)
            redirect_pc_d = act_taken ? i_res_target : i_res_next_pc;

        upd_d       = pop && (i_res_is_branch || head.pred_taken);
        upd_pc_d    = '0;
        upd_tgt_d   = '0;
        upd_taken_d = 1'b0;
        if (upd_d) begin
            upd_pc_d    = head.pc;
            upd_taken_d = act_taken;
            upd_tgt_d   = i_res_is_branch ? i_res_target : i_res_next_pc;
        end

        underflow_d = i_res_valid && !i_flush && empty;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q          <= '0;
            wr_q          <= '0;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_q         <= 1'b0;
            upd_pc_q      <= '0;
            upd_tgt_q     <= '0;
            upd_taken_q   <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            upd_q         <= upd_d;
            upd_pc_q      <= upd_pc_d;
            upd_tgt_q     <= upd_tgt_d;
            upd_taken_q   <= upd_taken_d;
            underflow_q   <= underflow_d;
        end
    end

    assign o_enq_ready         = !full;
    assign o_count             = cnt_q;
    assign o_redirect          = redirect_q;
    assign o_redirect_pc       = redirect_pc_q;
    assign o_btb_update        = upd_q;
    assign o_btb_update_pc     = upd_pc_q;
    assign o_btb_update_target = upd_tgt_q;
    assign o_btb_update_taken  = upd_taken_q;
    assign o_underflow         = underflow_q;
endmodule

// File: tb/tb_branch_prediction_queue.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_branch_prediction_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_enq_valid, o_enq_ready, i_enq_pred_taken;
    logic [XLEN-1:0] i_enq_pc, i_enq_pred_target;
    logic            i_res_valid, i_res_is_branch, i_res_taken, i_flush;
    logic [XLEN-1:0] i_res_target, i_res_next_pc;
    logic            o_redirect, o_btb_update, o_btb_update_taken, o_underflow;
    logic [XLEN-1:0] o_redirect_pc, o_btb_update_pc, o_btb_update_target;
    logic [2:0]      o_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic            pt;
        logic [XLEN-1:0] tgt;
    } rec_t;

    always #5 i_clk = ~i_clk;

    branch_prediction_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready), .i_enq_pc(i_enq_pc),
        .i_enq_pred_taken(i_enq_pred_taken), .i_enq_pred_target(i_enq_pred_target),
        .i_res_valid(i_res_valid), .i_res_is_branch(i_res_is_branch), .i_res_taken(i_res_taken),
        .i_res_target(i_res_target), .i_res_next_pc(i_res_next_pc), .i_flush(i_flush),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_btb_update(o_btb_update),
        .o_btb_update_pc(o_btb_update_pc), .o_btb_update_target(o_btb_update_target),
        .o_btb_update_taken(o_btb_update_taken), .o_count(o_count), .o_underflow(o_underflow)
    );

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle;
        i_enq_valid = 0; i_enq_pc = '0; i_enq_pred_taken = 0; i_enq_pred_target = '0;
        i_res_valid = 0; i_res_is_branch = 0; i_res_taken = 0; i_res_target = '0;
        i_res_next_pc = '0; i_flush = 0;
    endtask

    task automatic push(input logic [XLEN-1:0] pc, input logic pt, input logic [XLEN-1:0] tgt);
        i_enq_valid = 1; i_enq_pc = pc; i_enq_pred_taken = pt; i_enq_pred_target = tgt;
        step();
        idle();
    endtask

    task automatic set_res(input logic br, input logic tk, input logic [XLEN-1:0] tgt,
                           input logic [XLEN-1:0] npc);
        i_res_valid = 1; i_res_is_branch = br; i_res_taken = tk;
        i_res_target = tgt; i_res_next_pc = npc;
    endtask

    task automatic test_reset;
        idle();
        i_rst_n = 0;
        step(); step();
        tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", o_count); end
        tests++; if (o_enq_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", o_enq_ready); end
        tests++; if ({o_redirect, o_btb_update, o_underflow} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b want 000", {o_redirect, o_btb_update, o_underflow}); end
        tests++; if ({o_redirect_pc, o_btb_update_pc, o_btb_update_target} !== '0) begin fails++; $display("FAIL reset_data: got %h/%h/%h want 0", o_redirect_pc, o_btb_update_pc, o_btb_update_target); end
        i_rst_n = 1;
        step();
    endtask

    task automatic test_correct;
        push(32'h100, 1, 32'h200);
        tests++; if (o_count !== 3'd1) begin fails++; $display("FAIL correct_count1: got %0d want 1", o_count); end
        set_res(1, 1, 32'h200, 32'h104); step(); idle();
        tests++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL correct_redirect: got %b want 0", o_redirect); end
        tests++; if ({o_btb_update, o_btb_update_taken} !== 2'b11) begin fails++; $display("FAIL correct_upd: got %b want 11", {o_btb_update, o_btb_update_taken}); end
        tests++; if (o_btb_update_pc !== 32'h100 || o_btb_update_target !== 32'h200) begin fails++; $display("FAIL correct_upd_fields: got %h/%h want 100/200", o_btb_update_pc, o_btb_update_target); end
        tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL correct_count0: got %0d want 0", o_count); end
        step();
        tests++; if (o_btb_update !== 1'b0) begin fails++; $display("FAIL correct_pulse_len: got %b want 0", o_btb_update); end
    endtask

    task automatic test_dir_mispredict;
        push(32'h104, 0, 32'h0);
        push(32'h110, 0, 32'h0);
        push(32'h114, 0, 32'h0);
        tests++; if (o_count !== 3'd3) begin fails++; $display("FAIL mis_count3: got %0d want 3", o_count); end
        set_res(1, 1, 32'h300, 32'h108);
        i_enq_valid = 1; i_enq_pc = 32'h999;
        step(); idle();
        tests++; if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h300) begin fails++; $display("FAIL mis_redirect: got %b/%h want 1/300", o_redirect, o_redirect_pc); end
        tests++; if (o_btb_update !== 1'b1 || o_btb_update_taken !== 1'b1 || o_btb_update_pc !== 32'h104 || o_btb_update_target !== 32'h300) begin fails++; $display("FAIL mis_upd: got %b %b %h %h want 1 1 104 300", o_btb_update, o_btb_update_taken, o_btb_update_pc, o_btb_update_target); end
        tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL mis_count0: got %0d want 0", o_count); end
        set_res(1, 0, 32'h0, 32'h0); step(); idle();
        tests++; if (o_underflow !== 1'b1 || o_redirect !== 1'b0 || o_btb_update !== 1'b0) begin fails++; $display("FAIL mis_next_underflow: got u%b r%b b%b want u1 r0 b0", o_underflow, o_redirect, o_btb_update); end
        step();
    endtask

    task automatic test_false_hit;
        push(32'h108, 1, 32'h500);
        set_res(0, 0, 32'h0, 32'h10A); step(); idle();
        tests++; if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h10A) begin fails++; $display("FAIL fh_redirect: got %b/%h want 1/10a", o_redirect, o_redirect_pc); end
        tests++; if (o_btb_update !== 1'b1 || o_btb_update_taken !== 1'b0 || o_btb_update_target !== 32'h10A || o_btb_update_pc !== 32'h108) begin fails++; $display("FAIL fh_upd: got %b %b %h %h want 1 0 10a 108", o_btb_update, o_btb_update_taken, o_btb_update_target, o_btb_update_pc); end
        step();
    endtask

    task automatic test_full_wrap;
        rec_t q[$];
        logic [XLEN-1:0] pc;
        for (int i = 0; i < DEPTH; i++) begin
            pc = 32'h1000 + 32'(i * 4);
            push(pc, 1, pc + 32'h40);
            q.push_back('{pc, 1'b1, pc + 32'h40});
        end
        tests++; if (o_count !== 3'd4 || o_enq_ready !== 1'b0) begin fails++; $display("FAIL full_state: got cnt %0d rdy %b want 4 0", o_count, o_enq_ready); end
        push(32'hDEAD, 1, 32'hBEEF);
        tests++; if (o_count !== 3'd4) begin fails++; $display("FAIL full_ignore: got %0d want 4", o_count); end
        for (int i = 0; i < 10; i++) begin
            set_res(1, 1, q[0].tgt, 32'h0); step(); idle();
            tests++; if (o_btb_update !== 1'b1 || o_redirect !== 1'b0 || o_btb_update_pc !== q[0].pc) begin fails++; $display("FAIL wrap_order%0d: got %b %b %h want 1 0 %h", i, o_btb_update, o_redirect, o_btb_update_pc, q[0].pc); end
            void'(q.pop_front());
            tests++; if (o_count !== 3'd3) begin fails++; $display("FAIL wrap_cnt_pop%0d: got %0d want 3", i, o_count); end
            pc = 32'h2000 + 32'(i * 4);
            push(pc, 1, pc + 32'h40);
            q.push_back('{pc, 1'b1, pc + 32'h40});
            tests++; if (o_count !== 3'd4) begin fails++; $display("FAIL wrap_cnt_push%0d: got %0d want 4", i, o_count); end
        end
        while (q.size() > 0) begin
            set_res(1, 1, q[0].tgt, 32'h0); step(); idle();
            tests++; if (o_btb_update_pc !== q[0].pc) begin fails++; $display("FAIL drain_order: got %h want %h", o_btb_update_pc, q[0].pc); end
            void'(q.pop_front());
        end
        tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d want 0", o_count); end
    endtask

    task automatic test_flush_priority;
        push(32'h300, 0, 32'h0);
        push(32'h304, 0, 32'h0);
        push(32'h308, 0, 32'h0);
        set_res(1, 1, 32'h900, 32'h304);
        i_flush = 1; i_enq_valid = 1; i_enq_pc = 32'h30C;
        step(); idle();
        tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", o_count); end
        tests++; if ({o_redirect, o_btb_update, o_underflow} !== 3'b000) begin fails++; $display("FAIL flush_pulses: got %b want 000", {o_redirect, o_btb_update, o_underflow}); end
        step();
        tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL flush_enq_dropped: got %0d want 0", o_count); end
    endtask

    task automatic test_underflow_reset;
        set_res(1, 1, 32'h1, 32'h2); step(); idle();
        tests++; if (o_underflow !== 1'b1 || o_count !== 3'd0 || o_redirect !== 1'b0 || o_btb_update !== 1'b0) begin fails++; $display("FAIL underflow: got u%b c%0d r%b b%b want u1 c0 r0 b0", o_underflow, o_count, o_redirect, o_btb_update); end
        step();
        tests++; if (o_underflow !== 1'b0) begin fails++; $display("FAIL underflow_len: got %b want 0", o_underflow); end
        push(32'h400, 0, 32'h0);
        push(32'h404, 0, 32'h0);
        push(32'h408, 0, 32'h0);
        set_res(1, 1, 32'h777, 32'h404);
        #2 i_rst_n = 0;
        #1;
        tests++; if (o_count !== 3'd0 || o_enq_ready !== 1'b1) begin fails++; $display("FAIL async_reset: got c%0d rdy%b want c0 rdy1", o_count, o_enq_ready); end
        step();
        idle();
        i_rst_n = 1;
        step();
        tests++; if ({o_redirect, o_btb_update, o_underflow} !== 3'b000 || o_count !== 3'd0) begin fails++; $display("FAIL post_reset: got %b c%0d want 000 c0", {o_redirect, o_btb_update, o_underflow}, o_count); end
    endtask

    task automatic test_random;
        rec_t q[$];
        rec_t h;
        logic e_red, e_upd, e_upd_tk, e_und, fire, mis, pushed;
        logic [XLEN-1:0] e_rpc, e_upc, e_utgt;
        for (int c = 0; c < 400; c++) begin
            i_enq_valid       = ($urandom_range(0, 1) == 1);
            i_enq_pc          = $urandom;
            i_enq_pred_taken  = $urandom_range(0, 1);
            i_enq_pred_target = $urandom;
            i_res_valid       = ($urandom_range(0, 9) < 4);
            i_res_is_branch   = $urandom_range(0, 1);
            i_res_taken       = $urandom_range(0, 1);
            i_res_target      = $urandom;
            i_res_next_pc     = $urandom;
            i_flush           = ($urandom_range(0, 19) == 0);
            if (q.size() > 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    i_res_target = q[0].tgt;
                    i_res_taken  = q[0].pt;
                end
                if ($urandom_range(0, 3) != 0 && !q[0].pt) i_res_is_branch = 0;
            end
            tests++; if (o_enq_ready !== (q.size() < DEPTH) || o_count !== 3'(q.size())) begin fails++; $display("FAIL rnd_state c%0d: got rdy%b cnt%0d want rdy%b cnt%0d", c, o_enq_ready, o_count, q.size() < DEPTH, q.size()); end
            e_und = i_res_valid && !i_flush && q.size() == 0;
            fire  = i_res_valid && !i_flush && q.size() > 0;
            mis = 0; e_upd = 0; e_rpc = '0; e_upc = '0; e_utgt = '0; e_upd_tk = 0;
            if (fire) begin
                h = q[0];
                if (i_res_is_branch) mis = (h.pt != i_res_taken) || (i_res_taken && h.tgt != i_res_target);
                else                 mis = h.pt;
                e_rpc    = (i_res_is_branch && i_res_taken) ? i_res_target : i_res_next_pc;
                e_upd    = i_res_is_branch || h.pt;
                e_upc    = h.pc;
                e_upd_tk = i_res_is_branch && i_res_taken;
                e_utgt   = i_res_is_branch ? i_res_target : i_res_next_pc;
            end
            e_red  = mis;
            pushed = i_enq_valid && q.size() < DEPTH && !i_flush && !mis;
            if (i_flush || mis) q.delete();
            else begin
                if (fire) void'(q.pop_front());
                if (pushed) q.push_back('{i_enq_pc, i_enq_pred_taken, i_enq_pred_target});
            end
            step();
            tests++; if (o_redirect !== e_red || o_underflow !== e_und || o_btb_update !== e_upd) begin fails++; $display("FAIL rnd_pulses c%0d: got r%b u%b b%b want r%b u%b b%b", c, o_redirect, o_underflow, o_btb_update, e_red, e_und, e_upd); end
            if (e_red) begin
                tests++; if (o_redirect_pc !== e_rpc) begin fails++; $display("FAIL rnd_rpc c%0d: got %h want %h", c, o_redirect_pc, e_rpc); end
            end
            if (e_upd) begin
                tests++; if (o_btb_update_pc !== e_upc || o_btb_update_target !== e_utgt || o_btb_update_taken !== e_upd_tk) begin fails++; $display("FAIL rnd_upd c%0d: got %h %h %b want %h %h %b", c, o_btb_update_pc, o_btb_update_target, o_btb_update_taken, e_upc, e_utgt, e_upd_tk); end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        i_rst_n = 1;
        #2;
        test_reset();
        test_correct();
        test_dir_mispredict();
        test_false_hit();
        test_full_wrap();
        test_flush_priority();
        test_underflow_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
